// File: rtl/plt_pkg.sv
// Shared types for the PLT configuration sequencer.
// Mode encodings, sequencer states and config-width helper.
package plt_pkg;

  localparam logic [1:0] PLT_MODE_CFG  = 2'b00;
  localparam logic [1:0] PLT_MODE_USE  = 2'b01;
  localparam logic [1:0] PLT_MODE_TEST = 2'b10;
  localparam logic [1:0] PLT_MODE_IDLE = 2'b11;

  typedef enum logic [2:0] {
    S_IDLE,
    S_CLEAR,
    S_SHIFT,
    S_COMMIT,
    S_READBACK,
    S_CHECK,
    S_RUN
  } state_e;

  function automatic int cfg_width(input int n);
    return 4 * (n - 1);
  endfunction

endpackage

// File: rtl/plt_cfg_ctrl.sv
// Configuration sequencer for one PLT instance: load, read back,
// verify and commit a config word, then hold the PLT in usage mode.
module plt_cfg_ctrl
  import plt_pkg::*;
#(
  parameter int N         = 8,
  parameter int MAX_RETRY = 2,
  localparam int W        = cfg_width(N)
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         cfg_valid,
  output logic         cfg_ready,
  input  logic [W-1:0] cfg_word,
  input  logic         cfg_fast,
  input  logic         cfg_abort,
  output logic [1:0]   plt_mode,
  output logic         plt_clear,
  output logic         plt_config_in,
  output logic         plt_scan_enable,
  output logic [W-1:0] plt_scan_in,
  input  logic [W-1:0] plt_scan_out,
  output logic         busy,
  output logic         done,
  output logic         err,
  output logic [1:0]   retries
);

  localparam int CW = $clog2(W);

  state_e         state_q, state_d;
  logic [W-1:0]   shadow_q, shadow_d;
  logic           fast_q, fast_d;
  logic [CW-1:0]  cnt_q, cnt_d;
  logic [1:0]     retries_q, retries_d;
  logic           done_q, done_d;
  logic           err_q, err_d;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= S_IDLE;
      shadow_q  <= '0;
      fast_q    <= 1'b0;
      cnt_q     <= '0;
      retries_q <= '0;
      done_q    <= 1'b0;
      err_q     <= 1'b0;
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      fast_q    <= fast_d;
      cnt_q     <= cnt_d;
      retries_q <= retries_d;
      done_q    <= done_d;
      err_q     <= err_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    fast_d    = fast_q;
    cnt_d     = cnt_q;
    retries_d = retries_q;
    done_d    = 1'b0;
    err_d     = 1'b0;
    if (cfg_abort) begin
      state_d   = S_IDLE;
      shadow_d  = '0;
      fast_d    = 1'b0;
      cnt_d     = '0;
      retries_d = '0;
    end else begin
      unique case (state_q)
        S_IDLE, S_RUN: begin
          if (cfg_valid) begin
            state_d   = S_CLEAR;
            shadow_d  = cfg_word;
            fast_d    = cfg_fast;
            retries_d = '0;
          end
        end
        S_CLEAR: begin
          if (fast_q) begin
            state_d = S_COMMIT;
          end else begin
            state_d = S_SHIFT;
            cnt_d   = CW'(W - 1);
          end
        end
        // cnt_q is the bit index, so the chain sees the MSB first
        S_SHIFT: begin
          if (cnt_q == '0) state_d = S_READBACK;
          else             cnt_d   = cnt_q - 1'b1;
        end
        S_COMMIT: begin
          if (fast_q) begin
            state_d = S_READBACK;
          end else begin
            state_d = S_RUN;
            done_d  = 1'b1;
          end
        end
        S_READBACK: state_d = S_CHECK;
        S_CHECK: begin
          if (plt_scan_out == shadow_q) begin
            if (fast_q) begin
              state_d = S_RUN;
              done_d  = 1'b1;
            end else begin
              state_d = S_COMMIT;
            end
          end else if (!fast_q && 32'(retries_q) < MAX_RETRY) begin
            state_d   = S_CLEAR;
            retries_d = (retries_q == 2'd3) ? 2'd3 : retries_q + 2'd1;
          end else begin
            state_d = S_IDLE;
            err_d   = 1'b1;
          end
        end
        default: state_d = S_IDLE;
      endcase
    end
  end

  always_comb begin
    plt_mode        = PLT_MODE_IDLE;
    plt_clear       = 1'b0;
    plt_config_in   = 1'b0;
    plt_scan_enable = 1'b0;
    unique case (state_q)
      S_CLEAR:    plt_clear = 1'b1;
      S_SHIFT: begin
        plt_mode      = PLT_MODE_CFG;
        plt_config_in = shadow_q[cnt_q];
      end
      S_COMMIT: begin
        plt_mode        = PLT_MODE_CFG;
        plt_scan_enable = 1'b1;
      end
      S_READBACK: begin
        plt_mode        = PLT_MODE_TEST;
        plt_scan_enable = 1'b1;
      end
      S_RUN:      plt_mode = PLT_MODE_USE;
      default: ;
    endcase
  end

  assign cfg_ready   = (state_q == S_IDLE) || (state_q == S_RUN);
  assign busy        = !cfg_ready;
  assign plt_scan_in = shadow_q;
  assign done        = done_q;
  assign err         = err_q;
  assign retries     = retries_q;

endmodule
